// File: rtl/alu_arbiter_pkg.sv
// Shared types for the ALU sequencer/arbiter:
// opcodes, FSM states and opcode helpers.
package alu_pkg;

   typedef enum logic [3:0] {
      ALU_AND = 4'd0,
      ALU_OR  = 4'd1,
      ALU_ADD = 4'd2,
      ALU_NOR = 4'd3,
      ALU_EQ  = 4'd4,
      ALU_SUB = 4'd5,
      ALU_LT  = 4'd6,
      ALU_MUL = 4'd7,
      ALU_DIV = 4'd8
   } alu_op_e;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_EXEC = 2'd1,
      ST_RESP = 2'd2
   } arb_state_e;

   function automatic logic is_multi_cycle(
      input logic [3:0] op
   );
      return (op == ALU_MUL) || (op == ALU_DIV);
   endfunction

   function automatic logic is_legal(
      input logic [3:0] op
   );
      return op <= ALU_DIV;
   endfunction

endpackage

// File: rtl/alu_arbiter_if.sv
// Bus bundle between requesters, the shared ALU
// and the response consumer of alu_arbiter.
interface alu_arbiter_if #(
   parameter int WIDTH = 16
);
   logic             req0_valid;
   logic             req0_ready;
   logic [3:0]       req0_op;
   logic [WIDTH-1:0] req0_a;
   logic [WIDTH-1:0] req0_b;
   logic             req1_valid;
   logic             req1_ready;
   logic [3:0]       req1_op;
   logic [WIDTH-1:0] req1_a;
   logic [WIDTH-1:0] req1_b;
   logic [WIDTH-1:0] alu_a;
   logic [WIDTH-1:0] alu_b;
   logic [3:0]       alu_ctrl;
   logic [WIDTH-1:0] alu_out;
   logic             alu_carry;
   logic             rsp_valid;
   logic             rsp_ready;
   logic             rsp_id;
   logic [WIDTH-1:0] rsp_result;
   logic             rsp_carry;
   logic             rsp_zero;
   logic             rsp_err;

   modport master (
      output req0_valid, req0_op,
      output req0_a, req0_b,
      output req1_valid, req1_op,
      output req1_a, req1_b,
      output alu_out, alu_carry,
      output rsp_ready,
      input  req0_ready, req1_ready,
      input  alu_a, alu_b, alu_ctrl,
      input  rsp_valid, rsp_id,
      input  rsp_result, rsp_carry,
      input  rsp_zero, rsp_err
   );

   modport slave (
      input  req0_valid, req0_op,
      input  req0_a, req0_b,
      input  req1_valid, req1_op,
      input  req1_a, req1_b,
      input  alu_out, alu_carry,
      input  rsp_ready,
      output req0_ready, req1_ready,
      output alu_a, alu_b, alu_ctrl,
      output rsp_valid, rsp_id,
      output rsp_result, rsp_carry,
      output rsp_zero, rsp_err
   );
endinterface

// File: rtl/alu_arbiter_rr_arb.sv
// Two-way round-robin arbiter; grant is
// one-hot or zero, priority flips on advance.
module alu_rr_arb (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [1:0] valid_i,
   input  logic       advance_i,
   output logic [1:0] grant_o
);
   logic last_q;
   logic last_d;

   always_comb begin
      grant_o = 2'b00;
      unique case (1'b1)
         (valid_i == 2'b11):
            grant_o = last_q ? 2'b01 : 2'b10;
         (valid_i == 2'b01):
            grant_o = 2'b01;
         (valid_i == 2'b10):
            grant_o = 2'b10;
         default:
            grant_o = 2'b00;
      endcase
   end

   always_comb begin
      last_d = last_q;
      if (advance_i) last_d = grant_o[1];
   end

   // last_q resets to 1 so requester 0 wins first
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) last_q <= 1'b1;
      else        last_q <= last_d;
   end
endmodule

// File: rtl/alu_arbiter.sv
// Shares one combinational ALU between two requesters.
// Define ALU_ARB_DIVZERO_CHK_EN to trap DIV by zero.
module alu_arbiter
   import alu_pkg::*;
#(
   parameter int WIDTH     = 16,
   parameter int MULTI_LAT = 4
) (
   input logic          clk,
   input logic          rst_n,
   alu_arbiter_if.slave bus
);
   localparam int CW = $clog2(MULTI_LAT + 1);

   arb_state_e       state_q, state_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [WIDTH-1:0] alu_a_q, alu_a_d;
   logic [WIDTH-1:0] alu_b_q, alu_b_d;
   logic [3:0]       alu_ctrl_q, alu_ctrl_d;
   logic             rsp_id_q, rsp_id_d;
   logic [WIDTH-1:0] rsp_result_q, rsp_result_d;
   logic             rsp_carry_q, rsp_carry_d;
   logic             rsp_zero_q, rsp_zero_d;
   logic             rsp_err_q, rsp_err_d;

   logic             idle;
   logic [1:0]       grant;
   logic             hs;
   logic             sel_id;
   logic [3:0]       sel_op;
   logic [WIDTH-1:0] sel_a;
   logic [WIDTH-1:0] sel_b;
   logic             div_zero;
   logic             fast_rsp;
   logic             last_cnt;

   assign idle = (state_q == ST_IDLE);

   alu_rr_arb u_arb (
      .clk       (clk),
      .rst_n     (rst_n),
      .valid_i   ({bus.req1_valid,
                   bus.req0_valid} & {2{idle}}),
      .advance_i (hs),
      .grant_o   (grant)
   );

   assign hs     = |grant;
   assign sel_id = grant[1];
   assign sel_op = sel_id ? bus.req1_op : bus.req0_op;
   assign sel_a  = sel_id ? bus.req1_a  : bus.req0_a;
   assign sel_b  = sel_id ? bus.req1_b  : bus.req0_b;

`ifdef ALU_ARB_DIVZERO_CHK_EN
   assign div_zero = (sel_op == ALU_DIV) &&
                     (sel_b == '0);
`else
   assign div_zero = 1'b0;
`endif

   // these ops are answered without touching the ALU
   assign fast_rsp = !is_legal(sel_op) || div_zero;
   assign last_cnt = (cnt_q == CW'(1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= ST_IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         ST_IDLE:
            if (hs)
               state_d = fast_rsp ? ST_RESP : ST_EXEC;
         ST_EXEC:
            if (last_cnt) state_d = ST_RESP;
         ST_RESP:
            if (bus.rsp_ready) state_d = ST_IDLE;
         default:
            state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      bus.req0_ready = grant[0];
      bus.req1_ready = grant[1];
      bus.rsp_valid  = (state_q == ST_RESP);
   end

   always_comb begin
      cnt_d        = cnt_q;
      alu_a_d      = alu_a_q;
      alu_b_d      = alu_b_q;
      alu_ctrl_d   = alu_ctrl_q;
      rsp_id_d     = rsp_id_q;
      rsp_result_d = rsp_result_q;
      rsp_carry_d  = rsp_carry_q;
      rsp_zero_d   = rsp_zero_q;
      rsp_err_d    = rsp_err_q;
      if (hs) begin
         alu_a_d    = sel_a;
         alu_b_d    = sel_b;
         alu_ctrl_d = sel_op;
         rsp_id_d   = sel_id;
         cnt_d      = is_multi_cycle(sel_op) ?
                      CW'(MULTI_LAT) : CW'(1);
         unique case (1'b1)
            !is_legal(sel_op): begin
               rsp_result_d = '0;
               rsp_carry_d  = 1'b0;
               rsp_zero_d   = 1'b1;
               rsp_err_d    = 1'b1;
            end
            div_zero: begin
               rsp_result_d = '1;
               rsp_carry_d  = 1'b0;
               rsp_zero_d   = 1'b0;
               rsp_err_d    = 1'b1;
            end
            default: ;
         endcase
      end else if (state_q == ST_EXEC) begin
         cnt_d = cnt_q - CW'(1);
         if (last_cnt) begin
            rsp_result_d = bus.alu_out;
            rsp_carry_d  = (alu_ctrl_q == ALU_ADD) &&
                           bus.alu_carry;
            rsp_zero_d   = (bus.alu_out == '0);
            rsp_err_d    = 1'b0;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q        <= '0;
         alu_a_q      <= '0;
         alu_b_q      <= '0;
         alu_ctrl_q   <= '0;
         rsp_id_q     <= 1'b0;
         rsp_result_q <= '0;
         rsp_carry_q  <= 1'b0;
         rsp_zero_q   <= 1'b0;
         rsp_err_q    <= 1'b0;
      end else begin
         cnt_q        <= cnt_d;
         alu_a_q      <= alu_a_d;
         alu_b_q      <= alu_b_d;
         alu_ctrl_q   <= alu_ctrl_d;
         rsp_id_q     <= rsp_id_d;
         rsp_result_q <= rsp_result_d;
         rsp_carry_q  <= rsp_carry_d;
         rsp_zero_q   <= rsp_zero_d;
         rsp_err_q    <= rsp_err_d;
      end
   end

   assign bus.alu_a      = alu_a_q;
   assign bus.alu_b      = alu_b_q;
   assign bus.alu_ctrl   = alu_ctrl_q;
   assign bus.rsp_id     = rsp_id_q;
   assign bus.rsp_result = rsp_result_q;
   assign bus.rsp_carry  = rsp_carry_q;
   assign bus.rsp_zero   = rsp_zero_q;
   assign bus.rsp_err    = rsp_err_q;
endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Sequencer and arbiter sharing the single 16-bit combinational ALU between two requesters. Each requester issues an operation over a valid/ready handshake. The block round-robin arbitrates, registers operands and opcode onto the ALU inputs, and waits the required settle cycles (longer for multiply/divide). It then captures the result and returns it over a response handshake tagged with the requester ID.

## Interface
Parameters:
- WIDTH, 16, operand/result width
- MULTI_LAT, 4, settle cycles for MUL/DIV (min 1)

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- req0_valid / req1_valid  in  1  request pending
- req0_ready / req1_ready  out  1  request accepted this cycle
- req0_op / req1_op  in  4  opcode
- req0_a, req0_b / req1_a, req1_b  in  WIDTH  operands
- alu_a, alu_b  out  WIDTH  registered ALU operands
- alu_ctrl  out  4  registered ALU opcode
- alu_out  in  WIDTH  ALU result
- alu_carry  in  1  ALU carry
- rsp_valid  out  1  response available
- rsp_ready  in  1  response consumer ready
- rsp_id  out  1  requester that issued this op
- rsp_result  out  WIDTH  captured result
- rsp_carry  out  1  carry, ADD only, else 0
- rsp_zero  out  1  rsp_result == 0, computed here
- rsp_err  out  1  illegal opcode or (config) divide-by-zero

## Operation
- Opcodes: 0 AND, 1 OR, 2 ADD, 3 NOR, 4 EQ, 5 SUB, 6 LT, 7 MUL, 8 DIV. Codes 9–15 are illegal.
- FSM states: IDLE, EXEC, RESP.
- IDLE:
  - Arbitrate and assert the winner's ready combinationally.
  - On handshake, latch op/a/b into the alu_* registers and record rsp_id.
  - Go to EXEC, or to RESP directly for an illegal opcode.
- Arbitration: round-robin via last_grant (reset 1, so req0 wins first). With both valid, grant !last_grant. With one valid, grant it. last_grant updates on every grant.
- EXEC:
  - Counter loads 1 for ops 0–6, MULTI_LAT for 7–8, and decrements each cycle.
  - At count 1, capture alu_out and alu_carry into the rsp registers, then go to RESP.
- RESP:
  - rsp_valid=1; all rsp_* held stable until rsp_ready.
  - On rsp_valid && rsp_ready, return to IDLE.
- Illegal opcode: rsp_result=0, rsp_err=1, rsp_zero=1, rsp_carry=0.
- rsp_carry = captured alu_carry only when op==ADD, else 0.
- rsp_zero is derived from the captured result; the block has no ALU zero input.
- Both ready outputs are 0 outside IDLE. At most one ready is high in any cycle.

## Timing
- Reset values: all ready 0, alu_a/alu_b/alu_ctrl 0, rsp_valid 0, rsp_id 0, rsp_result 0, rsp_carry/rsp_zero/rsp_err 0, state IDLE.
- Latency from request handshake to rsp_valid:
  - 2 cycles for ops 0–6.
  - MULTI_LAT+1 for MUL/DIV.
  - 1 for illegal opcodes.
- Back-to-back: IDLE re-enters the cycle after the response handshake. Minimum issue interval is 3 cycles.
- Requester holding valid while the other is served keeps its request; no request is dropped.
- A request arriving during RESP waits until IDLE.
- Asynchronous reset mid-EXEC/RESP: state goes to IDLE immediately, rsp_valid drops, and the in-flight op is discarded.

## Configuration
- ALU_ARB_DIVZERO_CHK_EN defined:
  - DIV with b==0 skips EXEC and goes straight to RESP.
  - rsp_result={WIDTH{1'b1}}, rsp_err=1, rsp_zero=0; latency 1.
- Not defined: DIV with b==0 executes normally, result is whatever alu_out returns, rsp_err=0.

## Structure
- Shared package alu_pkg holds:
  - opcode enum: ALU_AND..ALU_DIV, 4-bit
  - arbiter FSM state enum
  - helper function is_multi_cycle(op)
- Sub-module alu_rr_arb: 2-way round-robin arbiter (valid[1:0] in, grant[1:0] out, one-hot/zero, advance input).
- Top level holds the FSM, counter, and operand/response registers.

## Test plan
- Reset release, req0 ADD a=16'hFFFF b=1 → rsp_valid at cycle +2, rsp_result=0, rsp_carry=1, rsp_zero=1, rsp_id=0.
- req0 and req1 both valid continuously with SUB 5−3 and AND 16'hF0F0&16'h0FF0 → grants alternate 0,1,0,1; results 2 and 16'h00F0.
- MUL 300×200, MULTI_LAT=4 → rsp_valid 5 cycles after handshake, rsp_result=16'hEA60, rsp_carry=0.
- Opcode 4'hC → rsp_err=1, rsp_result=0, latency 1; next legal op completes normally.
- DIV 9/0 with ALU_ARB_DIVZERO_CHK_EN → rsp_result=16'hFFFF, rsp_err=1. Without the macro: rsp_err=0, ALU-driven result.
- rsp_ready held low 10 cycles, then rst_n pulsed low → rsp_valid held stable until reset, then 0. No ready asserted during the hold.
